// File: rtl/mac_kxk_seq.sv
// Sequential KxK multiply-accumulate: one tap product per clock, multi-channel accumulation.
// Optional output saturation with overflow flag when MAC_SAT_EN is defined.
module mac_kxk_seq #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned K      = 3,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned OUT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [K*K*DATA_W-1:0]    data_in,
   input  logic [K*K*DATA_W-1:0]    weight_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     ovf
);

   localparam int unsigned NTAP   = K * K;
   localparam int unsigned WIN_W  = NTAP * DATA_W;
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned IDX_W  = $clog2(NTAP + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [WIN_W-1:0]         data_q, data_d;
   logic [WIN_W-1:0]         weight_q, weight_d;
   logic                     last_q, last_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;
   logic                     ovf_q, ovf_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;

   logic signed [DATA_W-1:0] d_tap, w_tap;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic [OUT_W-1:0]         res;
   logic                     res_ovf;
`ifdef MAC_SAT_EN
   logic [ACC_W-OUT_W:0]     sum_hi;
`endif

   // Current tap always sits in the low element; captured windows shift down per tap.
   always_comb begin
      d_tap = data_q[DATA_W-1:0];
      w_tap = weight_q[DATA_W-1:0];
      prod  = PROD_W'(d_tap) * PROD_W'(w_tap);
      sum   = acc_q + ACC_W'(prod);
   end

   // Conversion of the final sum to the output width.
   always_comb begin
`ifdef MAC_SAT_EN
      sum_hi  = sum[ACC_W-1:OUT_W-1];
      res_ovf = !((&sum_hi) || !(|sum_hi));
      if (!res_ovf)
         res = sum[OUT_W-1:0];
      else if (sum[ACC_W-1])
         res = {1'b1, {(OUT_W-1){1'b0}}};
      else
         res = {1'b0, {(OUT_W-1){1'b1}}};
`else
      res     = sum[OUT_W-1:0];
      res_ovf = 1'b0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      weight_d   = weight_q;
      last_d     = last_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      ovf_d      = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d   = data_in;
               weight_d = weight_in;
               last_d   = in_last;
               idx_d    = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            acc_d    = sum;
            data_d   = data_q >> DATA_W;
            weight_d = weight_q >> DATA_W;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NTAP - 1)) begin
               idx_d = '0;
               if (last_q) begin
                  out_data_d = res;
                  ovf_d      = res_ovf;
                  acc_d      = '0;
                  state_d    = OUT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == OUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         weight_q    <= '0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         weight_q    <= weight_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_kxk_seq.sv
// Self-checking bench for mac_kxk_seq: cycle-level reference model plus directed literal checks.
module tb_mac_kxk_seq;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned K      = 3;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned NTAP   = K * K;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_last;
   logic [NTAP*DATA_W-1:0]    data_in;
   logic [NTAP*DATA_W-1:0]    weight_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [OUT_W-1:0]          out_data;
   logic                      ovf;

   int n_checks = 0;
   int n_pass   = 0;

   mac_kxk_seq #(.DATA_W(DATA_W), .K(K), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
   endtask

   // Reference model: a window's whole dot product lands at accept; the block is then busy K*K edges.
   logic                    m_init = 1'b0;
   int                      m_busy;
   logic                    m_outv;
   logic                    m_last;
   logic signed [ACC_W-1:0] m_acc;
   logic [OUT_W-1:0]        m_res;
   logic                    m_ovf;

   always @(posedge clk) begin
      longint dot, s;
      logic signed [DATA_W-1:0] dv, wv;
      if (rst) begin
         m_init = 1'b1; m_busy = 0; m_outv = 1'b0; m_last = 1'b0;
         m_acc = '0; m_res = '0; m_ovf = 1'b0;
      end else if (m_init) begin
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_last) begin
               s = longint'(m_acc);
`ifdef MAC_SAT_EN
               if (s > (64'sd1 << (OUT_W-1)) - 1) begin
                  m_res = {1'b0, {(OUT_W-1){1'b1}}}; m_ovf = 1'b1;
               end else if (s < -(64'sd1 << (OUT_W-1))) begin
                  m_res = {1'b1, {(OUT_W-1){1'b0}}}; m_ovf = 1'b1;
               end else begin
                  m_res = OUT_W'(s); m_ovf = 1'b0;
               end
`else
               m_res = OUT_W'(s); m_ovf = 1'b0;
`endif
               m_acc  = '0;
               m_outv = 1'b1;
            end
         end else if (m_outv) begin
            if (out_ready) m_outv = 1'b0;
         end else if (in_valid) begin
            dot = 0;
            for (int i = 0; i < NTAP; i++) begin
               dv = data_in[i*DATA_W +: DATA_W];
               wv = weight_in[i*DATA_W +: DATA_W];
               dot += longint'(dv) * longint'(wv);
            end
            m_acc  = m_acc + ACC_W'(dot);
            m_last = in_last;
            m_busy = NTAP;
         end
      end
   end

   // Every-cycle comparison of DUT against the model.
   always @(negedge clk) begin
      if (m_init) begin
         chk("cyc_in_ready", longint'(in_ready), longint'(m_busy == 0 && !m_outv));
         chk("cyc_out_valid", longint'(out_valid), longint'(m_outv));
         if (m_outv) begin
            chk("cyc_out_data", longint'(out_data), longint'(m_res));
            chk("cyc_ovf", longint'(ovf), longint'(m_ovf));
         end
      end
   end

   // dsel/wsel: 0 = ramp 1..9 / row {1,0,-1}; 1 = all 127; 2 = all 1; 3 = junk
   task automatic load(input int dsel, input int wsel);
      int dv, wv;
      for (int i = 0; i < NTAP; i++) begin
         case (dsel)
            0: dv = i + 1;
            1: dv = 127;
            2: dv = 1;
            default: dv = -37 + 11 * i;
         endcase
         case (wsel)
            0: wv = 1 - (i % 3);
            1: wv = 127;
            2: wv = 1;
            default: wv = 93 - 7 * i;
         endcase
         data_in[i*DATA_W +: DATA_W]   = DATA_W'(dv);
         weight_in[i*DATA_W +: DATA_W] = DATA_W'(wv);
      end
   endtask

   task automatic do_window(input logic last);
      in_valid = 1'b1;
      in_last  = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("consume_out_valid", longint'(out_valid), 0);
      chk("consume_in_ready", longint'(in_ready), 1);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      data_in = '0; weight_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_ovf", longint'(ovf), 0);

      // Single window
      load(0, 0);
      do_window(1'b1);
      wait_out(n);
      chk("single_latency", n, 9);
      chk("single_data", longint'(out_data), 64'hFFFA);
      chk("single_ovf", longint'(ovf), 0);
      consume();

      // Two channels
      do_window(1'b0);
      wait_ready(n);
      chk("two_ch_accept_gap", n + 1, 10);
      do_window(1'b1);
      wait_out(n);
      chk("two_ch_latency", n, 9);
      chk("two_ch_data", longint'(out_data), 64'hFFF4);
      consume();

      // Backpressure
      do_window(1'b1);
      wait_out(n);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_data_stable", longint'(out_data), 64'hFFFA);
         chk("bp_in_ready", longint'(in_ready), 0);
         chk("bp_out_valid", longint'(out_valid), 1);
      end
      consume();

      // Overflow, two channels of 127*127
      load(1, 1);
      do_window(1'b0);
      wait_ready(n);
      do_window(1'b1);
      wait_out(n);
`ifdef MAC_SAT_EN
      chk("ovf_data", longint'(out_data), 32767);
      chk("ovf_flag", longint'(ovf), 1);
`else
      chk("ovf_data", longint'(out_data), 28178);
      chk("ovf_flag", longint'(ovf), 0);
`endif
      consume();

      // Reset while the tap-4 product would be added
      load(0, 0);
      do_window(1'b1);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", longint'(in_ready), 1);
      chk("midrst_out_valid", longint'(out_valid), 0);
      load(2, 2);
      do_window(1'b1);
      wait_out(n);
      chk("midrst_latency", n, 9);
      chk("midrst_data", longint'(out_data), 9);
      consume();

      // Ignored handshakes: out_ready in IDLE, in_valid during MAC
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ign_idle_in_ready", longint'(in_ready), 1);
      chk("ign_idle_out_valid", longint'(out_valid), 0);
      load(0, 2);
      do_window(1'b1);
      load(3, 3);
      in_valid = 1'b1;
      in_last  = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_out(n);
      chk("ign_latency", n, 6);
      chk("ign_data", longint'(out_data), 45);
      consume();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
